// File: rtl/vram_dma.sv
// vram_dma: writer-side master for the GPU VRAM port.
//
// Copies a block of bytes from CPU-side source memory into VRAM. VRAM is
// written only while vblank is high, so scan-out is never disturbed. This
// block owns the VRAM write port (data/address/cs) exclusively.
//
// Optional build macro: VRAM_DMA_FILL_EN
//   When defined, ports fill/fill_value are added. With fill=1 latched on
//   start, fill_value is written to length consecutive VRAM addresses and
//   no source reads are made.
//
// Ports:
//   clk        system clock (same clock as gpu_m)
//   rst        synchronous active-low reset
//   start      single-cycle transfer request, sampled only in IDLE
//   src_base   first source address, latched on start
//   dst_base   first VRAM address, latched on start
//   length     byte count, latched on start (0 gives an immediate done)
//   fill       (VRAM_DMA_FILL_EN only) fill mode select, latched on start
//   fill_value (VRAM_DMA_FILL_EN only) fill byte, latched on start
//   vblank     high while the GPU is outside the visible region
//   src_addr   source read address
//   src_rd     source read strobe; src_data is valid one cycle later
//   src_data   source read data
//   data       VRAM write data
//   address    VRAM write address
//   cs         VRAM write strobe, one byte per cycle
//   busy       high from the accepted start until done
//   done       one-cycle pulse in the cycle after the final write
module vram_dma #(
  parameter int VRAM_ADDR_WIDTH = 12,
  parameter int SRC_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SRC_ADDR_WIDTH-1:0]  src_base,
  input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]       length,
`ifdef VRAM_DMA_FILL_EN
  input  logic                       fill,
  input  logic [7:0]                 fill_value,
`endif
  input  logic                       vblank,
  output logic [SRC_ADDR_WIDTH-1:0]  src_addr,
  output logic                       src_rd,
  input  logic [7:0]                 src_data,
  output logic [7:0]                 data,
  output logic [VRAM_ADDR_WIDTH-1:0] address,
  output logic                       cs,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [SRC_ADDR_WIDTH-1:0]  src_ptr;
  logic [VRAM_ADDR_WIDTH-1:0] dst_ptr;
  logic [LEN_WIDTH-1:0]       issue_left;

  // One-entry pending write. pend_fresh marks the first cycle after the
  // byte was issued: the byte is then still on src_data (or is the fill
  // byte) and is captured into pend_data at the end of that cycle.
  logic                       pend_valid;
  logic                       pend_fresh;
  logic [7:0]                 pend_data;
  logic [VRAM_ADDR_WIDTH-1:0] pend_addr;
  logic                       done_r;

  logic                       issue;
  logic                       wr;
  logic                       accept;
  logic                       fill_mode;
  logic [7:0]                 fresh_byte;

`ifdef VRAM_DMA_FILL_EN
  logic                       fill_r;
  logic [7:0]                 fill_value_r;

  assign fill_mode  = fill_r;
  assign fresh_byte = fill_r ? fill_value_r : src_data;
`else
  assign fill_mode  = 1'b0;
  assign fresh_byte = src_data;
`endif

  // A start landing in the done cycle is ignored even though the state is
  // already back in IDLE.
  assign accept = (state == IDLE) && start && !done_r;

  // A pending byte goes out in any vblank cycle.
  assign wr = pend_valid && vblank;

  // Next-state and issue logic.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (length != '0)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // The write stage can accept when the slot is empty or drains now.
        issue = vblank && (issue_left != '0) && (!pend_valid || wr);
        if (issue && (issue_left == LEN_WIDTH'(1))) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (wr) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointers and the pending write register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      issue_left   <= '0;
      pend_valid   <= 1'b0;
      pend_fresh   <= 1'b0;
      pend_data    <= '0;
      pend_addr    <= '0;
      done_r       <= 1'b0;
`ifdef VRAM_DMA_FILL_EN
      fill_r       <= 1'b0;
      fill_value_r <= '0;
`endif
    end else begin
      state  <= state_nxt;
      done_r <= 1'b0;

      if (accept) begin
        src_ptr    <= src_base;
        dst_ptr    <= dst_base;
        issue_left <= length;
`ifdef VRAM_DMA_FILL_EN
        fill_r       <= fill;
        fill_value_r <= fill_value;
`endif
        if (length == '0) begin
          done_r <= 1'b1;
        end
      end

      if ((state == FLUSH) && wr) begin
        done_r <= 1'b1;
      end

      if (issue) begin
        if (!fill_mode) begin
          src_ptr <= src_ptr + 1'b1;
        end
        dst_ptr    <= dst_ptr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end

      if (pend_fresh) begin
        pend_data <= fresh_byte;
      end
      pend_fresh <= issue;

      // A new issue refills the slot even if the old byte drains this cycle.
      if (issue) begin
        pend_valid <= 1'b1;
        pend_addr  <= dst_ptr;
      end else if (wr) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign src_addr = src_ptr;
  assign src_rd   = issue && !fill_mode;
  assign data     = pend_fresh ? fresh_byte : pend_data;
  assign address  = pend_addr;
  assign cs       = wr;
  assign busy     = (state != IDLE);
  assign done     = done_r;

endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: self-checking bench for vram_dma.
//
// A table of copy transfers is applied in a loop; each expected VRAM write
// is pushed to a scoreboard queue when the transfer is started and popped
// by a monitor on every cs. Hand-written sequences cover vblank pause,
// start while busy, start in the done cycle, reset mid-transfer and (when
// VRAM_DMA_FILL_EN is defined) fill mode.
module tb_vram_dma;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] src_base;
  logic [11:0] dst_base;
  logic [12:0] length;
`ifdef VRAM_DMA_FILL_EN
  logic        fill;
  logic [7:0]  fill_value;
  logic        fill_on;
`endif
  logic        vblank;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data;
  logic [7:0]  data;
  logic [11:0] address;
  logic        cs;
  logic        busy;
  logic        done;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    string       name;
    logic [15:0] src;
    logic [11:0] dst;
    logic [12:0] len;
    int          lat;
  } vec_t;

  wr_t        exp_q[$];
  vec_t       vecs[5];
  logic [7:0] mem [0:65535];
  int         vectors;
  int         miscompares;

  vram_dma dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .length     (length),
`ifdef VRAM_DMA_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .vblank     (vblank),
    .src_addr   (src_addr),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .data       (data),
    .address    (address),
    .cs         (cs),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory with one cycle of read latency.
  always @(posedge clk) begin
    if (src_rd) begin
      src_data <= mem[src_addr];
    end
  end

  // Scoreboard monitor: every VRAM write must match the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (cs) begin
      vectors++;
      if (!vblank) begin
        miscompares++;
        $display("[TB] FAIL cs_vblank: cs=1 with vblank=%0b, required vblank=1", vblank);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL write_extra: got write addr=%03h data=%02h, required no write", address, data);
      end else begin
        e = exp_q.pop_front();
        if (address !== e.addr || data !== e.data) begin
          miscompares++;
          $display("[TB] FAIL write: got addr=%03h data=%02h, required addr=%03h data=%02h",
                   address, data, e.addr, e.data);
        end
      end
    end
    if (src_rd && !vblank) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL src_rd_vblank: src_rd=1 with vblank=0, required src_rd=0");
    end
`ifdef VRAM_DMA_FILL_EN
    if (fill_on) begin
      vectors++;
      if (src_rd !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_src_rd: got src_rd=%0b, required 0", src_rd);
      end
    end
`endif
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drives a one-cycle start from just after a clock edge and pushes the
  // expected writes. Returns one cycle after the start cycle.
  task automatic applyStimulus(input logic [15:0] s, input logic [11:0] d, input logic [12:0] n);
    wr_t e;
    @(posedge clk);
    #1;
    src_base = s;
    dst_base = d;
    length   = n;
    start    = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      e.addr = d + 12'(i);
      e.data = mem[s + 16'(i)];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done, counting cycles from the start cycle (cycle 0).
  task automatic waitDone(input string name, input int n0, input int exp_lat);
    int  n;
    bit  seen;
    seen = 1'b0;
    for (n = n0; n <= n0 + 200; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: no done within %0d cycles, required done at cycle %0d", name, n0 + 200, exp_lat);
    end else if (n != exp_lat) begin
      miscompares++;
      $display("[TB] FAIL %s_latency: done at cycle %0d, required cycle %0d", name, n, exp_lat);
    end
    checkOutput({name, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    start       = 1'b0;
    src_base    = '0;
    dst_base    = '0;
    length      = '0;
    vblank      = 1'b1;
    src_data    = '0;
`ifdef VRAM_DMA_FILL_EN
    fill        = 1'b0;
    fill_value  = '0;
    fill_on     = 1'b0;
`endif

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
    end
    mem[16'h0100] = 8'hAA;
    mem[16'h0101] = 8'hBB;
    mem[16'h0102] = 8'hCC;
    mem[16'h0103] = 8'hDD;

    // Latency = cycles from start cycle to done: length + 2, or 1 if empty.
    vecs[0] = '{"copy4",  16'h0100, 12'h020, 13'd4,  6};
    vecs[1] = '{"wrap3",  16'h0200, 12'hFFE, 13'd3,  5};
    vecs[2] = '{"len0",   16'h0300, 12'h050, 13'd0,  1};
    vecs[3] = '{"len1",   16'h0400, 12'h7F0, 13'd1,  3};
    vecs[4] = '{"copy16", 16'h0500, 12'h000, 13'd16, 18};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cs",       32'(cs),       32'd0);
    checkOutput("rst_src_rd",   32'(src_rd),   32'd0);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_done",     32'(done),     32'd0);
    checkOutput("rst_src_addr", 32'(src_addr), 32'd0);
    checkOutput("rst_address",  32'(address),  32'd0);
    checkOutput("rst_data",     32'(data),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table of copies with vblank held high.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].src, vecs[i].dst, vecs[i].len);
      waitDone(vecs[i].name, 1, vecs[i].lat);
    end

    // Pause: vblank low for 5 cycles after the second write.
    applyStimulus(16'h0100, 12'h020, 13'd4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    vblank = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("pause_cs",      32'(cs),      32'd0);
      checkOutput("pause_data",    32'(data),    32'hCC);
      checkOutput("pause_address", 32'(address), 32'h022);
      checkOutput("pause_busy",    32'(busy),    32'd1);
    end
    @(posedge clk);
    #1;
    vblank = 1'b1;
    waitDone("pause", 9, 11);

    // Start while busy, then start in the done cycle: both ignored.
    applyStimulus(16'h0600, 12'h300, 13'd8);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    src_base = 16'h0700;
    dst_base = 12'h400;
    length   = 13'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("busy_start", 4, 10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("done_start_busy", 32'(busy), 32'd0);
    checkOutput("done_start_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("done_start_idle", 32'(busy), 32'd0);
    end

    // Reset after 2 of 8 bytes are written.
    applyStimulus(16'h0800, 12'h500, 13'd8);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("abort_cs",     32'(cs),     32'd0);
    checkOutput("abort_busy",   32'(busy),   32'd0);
    checkOutput("abort_done",   32'(done),   32'd0);
    checkOutput("abort_src_rd", 32'(src_rd), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    applyStimulus(16'h0100, 12'h020, 13'd4);
    waitDone("after_reset", 1, 6);

`ifdef VRAM_DMA_FILL_EN
    // Fill 0x5A into 0x100..0x102 with no source reads.
    begin
      wr_t e;
      @(posedge clk);
      #1;
      fill       = 1'b1;
      fill_value = 8'h5A;
      src_base   = 16'h0000;
      dst_base   = 12'h100;
      length     = 13'd3;
      start      = 1'b1;
      fill_on    = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e.addr = 12'h100 + 12'(i);
        e.data = 8'h5A;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone("fill", 1, 5);
      fill_on = 1'b0;
      fill    = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- Writer-side master for the GPU VRAM port. It drives the GPU's data/address/cs inputs.
- Copies a block of bytes from CPU-side memory into VRAM, writing only while the GPU is in vertical blanking so that scan-out is never disturbed.
- Sits between the CPU bus glue and gpu_m. It owns the VRAM write port exclusively.

Parameters:
- VRAM_ADDR_WIDTH, 12, VRAM byte address width; must match the GPU VRAM port.
- SRC_ADDR_WIDTH, 16, source memory address width.
- LEN_WIDTH, 13, transfer length counter width, in bytes.

Ports:
- clk  in  1  system clock, same clock as gpu_m.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_base  in  SRC_ADDR_WIDTH  first source address, latched on start.
- dst_base  in  VRAM_ADDR_WIDTH  first VRAM address, latched on start.
- length  in  LEN_WIDTH  byte count, latched on start.
- vblank  in  1  high while the GPU is outside the visible region (not vvisible).
- src_addr  out  SRC_ADDR_WIDTH  source memory read address.
- src_rd  out  1  read strobe; source data is valid exactly 1 cycle later.
- src_data  in  8  source read data.
- data  out  8  VRAM write data.
- address  out  VRAM_ADDR_WIDTH  VRAM write address.
- cs  out  1  VRAM write strobe; one byte is written per cycle cs=1.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the last byte is written.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - cs, src_rd, busy and done go to 0; src_addr, address and data go to 0.
  - All counters are cleared.
  - A reset mid-transfer aborts it immediately, with no further cs and no done.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 latches src_base, dst_base and length, then goes to RUN with busy=1 on the next cycle.
  - If length=0: no RUN; done=1 for one cycle and busy stays 0.
- Read stage (RUN):
  - src_rd=1 when vblank=1, bytes remain to issue, and the write stage can accept.
  - "Can accept" means no byte is pending, or the pending byte is written in this same cycle.
  - The issue pointer increments src_addr by 1 per issued read.
  - Source addresses do not wrap within a legal transfer (software guarantees this).
- Write stage:
  - The byte returned 1 cycle after src_rd lands in a 1-entry pending register, together with its destination address.
  - A pending byte is driven onto data/address with cs=1 in any cycle vblank=1; otherwise it holds, with cs=0 and data/address stable.
- Throughput: 1 byte/clk while vblank stays high. The first cs comes 1 cycle after the first src_rd.
- Destination address is dst_base plus the byte index, modulo 2^VRAM_ADDR_WIDTH (wraps 0xFFF to 0x000 at default width).
- When the final read is issued, the state goes to FLUSH. FLUSH waits until the pending byte is written.
- done=1 for exactly one cycle, in the cycle after the final cs. busy drops in that same cycle. The state then returns to IDLE.
- vblank falling mid-transfer:
  - The read issued in the edge cycle still returns and is held pending.
  - No cs is asserted while vblank=0.
  - The transfer resumes on the next vblank with no byte lost or duplicated.
- start while busy=1 is ignored.
- start on the same cycle as done is ignored; it is accepted only once the state has returned to IDLE.
- cs and src_rd are never high while vblank=0, except src_rd in the cycle vblank falls if it was sampled high.
- The sequence is strictly registered: outputs depend only on registers and the current vblank/start.

Optional Feature:
- Macro: VRAM_DMA_FILL_EN.
- Defined:
  - Adds input fill (1 bit) and input fill_value (8 bits), both latched on start.
  - When fill=1, no source reads occur (src_rd stays 0).
  - fill_value is written to length consecutive VRAM addresses at 1 byte/clk during vblank, with the same wrap, pause, done and busy rules. The first cs comes 1 cycle after RUN entry.
  - fill=0 behaves as a normal copy.
- Undefined: the fill and fill_value ports do not exist, and the block is copy-only.

Test Plan:
- Copy with vblank held at 1: src_base=0x0100, dst_base=0x020, length=4, source bytes AA,BB,CC,DD.
  - Expect cs on 4 consecutive cycles with address 0x020..0x023 and data AA..DD.
  - Expect done 1 cycle after the last cs.
- Pause: same copy, but vblank drops after the 2nd cs for 5 cycles.
  - Expect no cs during those 5 cycles and byte CC held on data.
  - Expect writes to resume at 0x022 and exactly 4 writes in total.
- Wrap: dst_base=0xFFE, length=3.
  - Expect addresses 0xFFE, 0xFFF, 0x000.
- Edge cases:
  - length=0: expect a done pulse, busy stays 0, and cs is never asserted.
  - start while busy: expect the second request ignored; write count and addresses come only from the first request.
- Reset mid-transfer: rst=0 after 2 of 8 bytes are written.
  - Expect cs, busy and done all 0 on the next edge and no done pulse.
  - Expect a fresh start afterwards to work.
- With VRAM_DMA_FILL_EN defined: fill=1, fill_value=0x5A, dst_base=0x100, length=3.
  - Expect 0x5A written to 0x100..0x102 with src_rd always 0.
